// File: rtl/ysyx_24110015_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_pkg: shared arbiter types and AXI constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ysyx_24110015_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    M0_RD = 2'd1,
    M1_RD = 2'd2,
    M1_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axi_if.sv
// ---------------------------------------------------------------------------
// axi_if: 32-bit AXI4-Lite bundle with master/slave views.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface axi_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
           wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
           wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_24110015_arb_wdog.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_arb_wdog: granted-cycle counter with sticky expiry flag.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_24110015_arb_wdog #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

      logic [CW-1:0] cnt;
      logic          flag;

      // Counter saturates at LIMIT so a long-stalled transaction cannot wrap it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt  <= '0;
          flag <= 1'b0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable) begin
          if (cnt != LIMIT) cnt <= cnt + 1'b1;
          if (cnt == LIMIT - 1'b1) flag <= 1'b1;
        end
      end

      assign expired = flag;
    end else begin : g_no_wdog
      logic unused_wdog;
      assign unused_wdog = &{1'b0, clk, rst, clear, enable};
      assign expired     = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ysyx_24110015_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_axi_arbiter: 2:1 AXI4-Lite arbiter, fetch (m0) vs LSU (m1).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_24110015_axi_arbiter
  import ysyx_24110015_pkg::*;
#(
  parameter int          LSU_PRIO    = 1,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic       clk,
  input  logic       rst,
  axi_if.slave       m0,
  axi_if.slave       m1,
  axi_if.master      s,
  output logic [1:0] grant,
  output logic       bus_timeout
);

  arb_state_e state;
  logic       last_m1;
  logic       req0, req1, wr_req, win_m1;

  always_comb begin
    req0   = m0.arvalid;
    wr_req = m1.awvalid | m1.wvalid;
    req1   = m1.arvalid | wr_req;
    // On a tie m1 wins under priority mode, otherwise whoever did not win last.
    win_m1 = req1 & (~req0 | (LSU_PRIO != 0) | ~last_m1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= GRANT_NONE;
      last_m1 <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            last_m1 <= win_m1;
            if (win_m1) begin
              state <= wr_req ? M1_WR : M1_RD;
              grant <= GRANT_M1;
            end else begin
              state <= M0_RD;
              grant <= GRANT_M0;
            end
          end
        end
        M0_RD, M1_RD: begin
          if (s.rvalid & s.rready) begin
            state <= IDLE;
            grant <= GRANT_NONE;
          end
        end
        M1_WR: begin
          if (s.bvalid & s.bready) begin
            state <= IDLE;
            grant <= GRANT_NONE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

  // Pure passthrough in granted states; everything not owned is held at zero.
  always_comb begin
    m0.arready = 1'b0; m0.rdata = '0; m0.rresp = '0; m0.rvalid = 1'b0;
    m0.awready = 1'b0; m0.wready = 1'b0; m0.bresp = '0; m0.bvalid = 1'b0;
    m1.arready = 1'b0; m1.rdata = '0; m1.rresp = '0; m1.rvalid = 1'b0;
    m1.awready = 1'b0; m1.wready = 1'b0; m1.bresp = '0; m1.bvalid = 1'b0;
    s.araddr  = '0; s.arsize = '0; s.arvalid = 1'b0; s.rready = 1'b0;
    s.awaddr  = '0; s.awsize = '0; s.awvalid = 1'b0;
    s.wdata   = '0; s.wstrb  = '0; s.wvalid  = 1'b0; s.bready = 1'b0;
    case (state)
      M0_RD: begin
        s.araddr   = m0.araddr;
        s.arsize   = m0.arsize;
        s.arvalid  = m0.arvalid;
        s.rready   = m0.rready;
        m0.arready = s.arready;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
      end
      M1_RD: begin
        s.araddr   = m1.araddr;
        s.arsize   = m1.arsize;
        s.arvalid  = m1.arvalid;
        s.rready   = m1.rready;
        m1.arready = s.arready;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
      end
      M1_WR: begin
        s.awaddr   = m1.awaddr;
        s.awsize   = m1.awsize;
        s.awvalid  = m1.awvalid;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid;
        s.bready   = m1.bready;
        m1.awready = s.awready;
        m1.wready  = s.wready;
        m1.bresp   = s.bresp;
        m1.bvalid  = s.bvalid;
      end
      default: ;
    endcase
  end

  ysyx_24110015_arb_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (bus_timeout)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110015_axi_arbiter: two arbiters (priority+watchdog, round-robin)
// driven by shared stimulus.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_24110015_axi_arbiter;

  typedef struct packed {
    logic [31:0] araddr; logic [2:0] arsize; logic arvalid; logic rready;
    logic [31:0] awaddr; logic [2:0] awsize; logic awvalid;
    logic [31:0] wdata;  logic [3:0] wstrb;  logic wvalid;  logic bready;
  } mreq_t;

  typedef struct packed {
    logic arready; logic [31:0] rdata; logic [1:0] rresp; logic rvalid;
    logic awready; logic wready; logic [1:0] bresp; logic bvalid;
  } srsp_t;

  typedef struct {
    logic [3:0] req;   // {m0 ar, m1 ar, m1 aw, m1 w}
    logic [1:0] ga;    // grant of the priority instance
    logic [1:0] gb;    // grant of the round-robin instance
    logic       sar_a; // s.arvalid of the priority instance once granted
  } vec_t;

  logic       clk, rst;
  mreq_t      m0_in, m1_in;
  srsp_t      s_in;
  srsp_t      m0_out [2];
  srsp_t      m1_out [2];
  mreq_t      s_out  [2];
  logic [1:0] grant_o [2];
  logic       tout   [2];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    axi_if m0 ();
    axi_if m1 ();
    axi_if s ();
    assign {m0.araddr, m0.arsize, m0.arvalid, m0.rready, m0.awaddr, m0.awsize,
            m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready} = m0_in;
    assign {m1.araddr, m1.arsize, m1.arvalid, m1.rready, m1.awaddr, m1.awsize,
            m1.awvalid, m1.wdata, m1.wstrb, m1.wvalid, m1.bready} = m1_in;
    assign {s.arready, s.rdata, s.rresp, s.rvalid, s.awready, s.wready,
            s.bresp, s.bvalid} = s_in;
    assign m0_out[k] = {m0.arready, m0.rdata, m0.rresp, m0.rvalid, m0.awready,
                        m0.wready, m0.bresp, m0.bvalid};
    assign m1_out[k] = {m1.arready, m1.rdata, m1.rresp, m1.rvalid, m1.awready,
                        m1.wready, m1.bresp, m1.bvalid};
    assign s_out[k]  = {s.araddr, s.arsize, s.arvalid, s.rready, s.awaddr, s.awsize,
                        s.awvalid, s.wdata, s.wstrb, s.wvalid, s.bready};

    ysyx_24110015_axi_arbiter #(
      .LSU_PRIO    (k == 0 ? 1 : 0),
      .TIMEOUT_CYC (k == 0 ? 8 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0),
      .m1          (m1),
      .s           (s),
      .grant       (grant_o[k]),
      .bus_timeout (tout[k])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_in = '0; m1_in = '0; s_in = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model: who owns the bus, whether it is a write, and watchdog age.
  int  own  [2];   // 0 none, 1 m0, 2 m1
  bit  mwr  [2];
  bit  lastm1 [2];
  int  age  [2];
  bit  stky [2];
  int  prio_p [2] = '{1, 0};
  int  tmo_p  [2] = '{8, 0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 0; mwr[k] = 1'b0; lastm1[k] = 1'b1; age[k] = 0; stky[k] = 1'b0;
    end
  endtask

  task automatic model_out(input int k, output srsp_t e0, output srsp_t e1,
                           output mreq_t es, output logic [1:0] eg);
    mreq_t src;
    srsp_t fwd;
    e0 = '0; e1 = '0; es = '0; eg = 2'b00;
    src = (own[k] == 1) ? m0_in : m1_in;
    fwd = '0;
    if (own[k] != 0) eg = (own[k] == 1) ? 2'b01 : 2'b10;
    if (own[k] != 0 && !mwr[k]) begin
      es.araddr = src.araddr; es.arsize = src.arsize;
      es.arvalid = src.arvalid; es.rready = src.rready;
      fwd.arready = s_in.arready; fwd.rdata = s_in.rdata;
      fwd.rresp = s_in.rresp; fwd.rvalid = s_in.rvalid;
    end else if (own[k] != 0) begin
      es.awaddr = src.awaddr; es.awsize = src.awsize; es.awvalid = src.awvalid;
      es.wdata = src.wdata; es.wstrb = src.wstrb; es.wvalid = src.wvalid;
      es.bready = src.bready;
      fwd.awready = s_in.awready; fwd.wready = s_in.wready;
      fwd.bresp = s_in.bresp; fwd.bvalid = s_in.bvalid;
    end
    if (own[k] == 1) e0 = fwd;
    if (own[k] == 2) e1 = fwd;
  endtask

  task automatic model_step(input int k);
    bit r0, r1, wreq, w1, done;
    if (own[k] == 0) begin
      r0   = m0_in.arvalid;
      wreq = m1_in.awvalid | m1_in.wvalid;
      r1   = m1_in.arvalid | wreq;
      if (r0 && r1) w1 = (prio_p[k] != 0) ? 1'b1 : !lastm1[k];
      else          w1 = r1;
      if (r0 || r1) begin
        own[k] = w1 ? 2 : 1; mwr[k] = w1 && wreq; lastm1[k] = w1; age[k] = 0;
      end
    end else begin
      if (mwr[k]) done = s_in.bvalid && m1_in.bready;
      else        done = s_in.rvalid && ((own[k] == 1) ? m0_in.rready : m1_in.rready);
      age[k]++;
      if (tmo_p[k] > 0 && age[k] >= tmo_p[k]) stky[k] = 1'b1;
      if (done) own[k] = 0;
    end
  endtask

  vec_t vecs [9];

  initial begin
    srsp_t e0, e1;
    mreq_t es;
    logic [1:0] eg;

    vecs[0] = '{4'b0000, 2'b00, 2'b00, 1'b0};
    vecs[1] = '{4'b1000, 2'b01, 2'b01, 1'b1};
    vecs[2] = '{4'b0100, 2'b10, 2'b10, 1'b1};
    vecs[3] = '{4'b0010, 2'b10, 2'b10, 1'b0};
    vecs[4] = '{4'b0110, 2'b10, 2'b10, 1'b0};
    vecs[5] = '{4'b1100, 2'b10, 2'b01, 1'b1};
    vecs[6] = '{4'b1001, 2'b10, 2'b01, 1'b0};
    vecs[7] = '{4'b1111, 2'b10, 2'b01, 1'b0};
    vecs[8] = '{4'b0001, 2'b10, 2'b10, 1'b0};

    // Reset state with busy inputs: everything must read as idle.
    rst = 1'b1;
    m0_in = {$urandom, $urandom, $urandom, $urandom};
    m1_in = {$urandom, $urandom, $urandom, $urandom};
    s_in  = {$urandom, $urandom};
    m0_in.arvalid = 1'b1; m1_in.wvalid = 1'b1; s_in.rvalid = 1'b1; s_in.bvalid = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_grant%0d", k), grant_o[k], 2'b00);
      chk($sformatf("rst_timeout%0d", k), tout[k], 1'b0);
      chk($sformatf("rst_s%0d", k), s_out[k], '0);
      chk($sformatf("rst_m0m1_%0d", k), {m0_out[k], m1_out[k]}, '0);
    end

    // Arbitration table from reset.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      m0_in.arvalid = vecs[i].req[3]; m1_in.arvalid = vecs[i].req[2];
      m1_in.awvalid = vecs[i].req[1]; m1_in.wvalid  = vecs[i].req[0];
      #1;
      chk($sformatf("idle_nocomb_v%0d", i),
          {s_out[0].arvalid, s_out[0].awvalid, s_out[0].wvalid,
           s_out[1].arvalid, s_out[1].awvalid, s_out[1].wvalid}, 6'b0);
      tick();
      chk($sformatf("grant_prio_v%0d", i), grant_o[0], vecs[i].ga);
      chk($sformatf("grant_rr_v%0d", i), grant_o[1], vecs[i].gb);
      chk($sformatf("s_arvalid_v%0d", i), s_out[0].arvalid, vecs[i].sar_a);
    end

    // Single fetch read, slave accepts after 2 cycles.
    do_reset();
    m0_in.araddr = 32'h8000_0000; m0_in.arvalid = 1'b1; m0_in.rready = 1'b1;
    tick();
    chk("t1_grant", grant_o[0], 2'b01);
    chk("t1_s_ar", {s_out[0].araddr, s_out[0].arvalid}, {32'h8000_0000, 1'b1});
    tick();
    chk("t1_arready_lo", m0_out[0].arready, 1'b0);
    tick();
    s_in.arready = 1'b1; #1;
    chk("t1_arready_hi", m0_out[0].arready, 1'b1);
    tick();
    m0_in.arvalid = 1'b0; s_in.arready = 1'b0;
    s_in.rvalid = 1'b1; s_in.rdata = 32'h0000_0413; #1;
    chk("t1_r", {m0_out[0].rvalid, m0_out[0].rdata}, {1'b1, 32'h0000_0413});
    tick();
    chk("t1_r_once", m0_out[0].rvalid, 1'b0);
    chk("t1_grant_end", grant_o[0], 2'b00);
    chk("t1_stray_r", s_out[0].rready, 1'b0);

    // Simultaneous reads under priority: m1 first, then one idle cycle, then m0.
    do_reset();
    m0_in.arvalid = 1'b1; m0_in.rready = 1'b1; m0_in.araddr = 32'h8000_0100;
    m1_in.arvalid = 1'b1; m1_in.rready = 1'b1; m1_in.araddr = 32'h8000_2000;
    s_in.arready = 1'b1;
    tick();
    chk("t2_grant_m1", grant_o[0], 2'b10);
    chk("t2_s_araddr", s_out[0].araddr, 32'h8000_2000);
    tick();
    m1_in.arvalid = 1'b0; s_in.rvalid = 1'b1; s_in.rdata = 32'h1234_5678; #1;
    chk("t2_m1_r", {m1_out[0].rvalid, m1_out[0].rdata, m0_out[0].rvalid},
        {1'b1, 32'h1234_5678, 1'b0});
    tick();
    s_in.rvalid = 1'b0; #1;
    chk("t2_idle_gap", {grant_o[0], s_out[0].arvalid}, {2'b00, 1'b0});
    tick();
    chk("t2_grant_m0", grant_o[0], 2'b01);

    // Write with W a cycle ahead of AW while fetch waits.
    do_reset();
    m0_in.arvalid = 1'b1;
    m1_in.wvalid = 1'b1; m1_in.wdata = 32'hDEAD_BEEF; m1_in.wstrb = 4'hF; m1_in.bready = 1'b1;
    tick();
    chk("t3_grant", grant_o[0], 2'b10);
    chk("t3_s_w", {s_out[0].wvalid, s_out[0].wdata, s_out[0].wstrb, s_out[0].awvalid,
                   s_out[0].arvalid}, {1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0});
    s_in.wready = 1'b1; #1;
    chk("t3_wready", {m1_out[0].wready, m0_out[0].arready}, 2'b10);
    tick();
    m1_in.wvalid = 1'b0; m1_in.awvalid = 1'b1; m1_in.awaddr = 32'h8000_1000;
    s_in.wready = 1'b0; s_in.awready = 1'b1; #1;
    chk("t3_s_aw", {s_out[0].awvalid, s_out[0].awaddr, m1_out[0].awready},
        {1'b1, 32'h8000_1000, 1'b1});
    tick();
    m1_in.awvalid = 1'b0; s_in.awready = 1'b0; s_in.bvalid = 1'b1; s_in.bresp = 2'b00; #1;
    chk("t3_b", {m1_out[0].bvalid, m1_out[0].bresp, s_out[0].bready, m0_out[0].arready},
        {1'b1, 2'b00, 1'b1, 1'b0});
    tick();
    s_in.bvalid = 1'b0; #1;
    chk("t3_idle", grant_o[0], 2'b00);
    tick();
    chk("t3_m0_next", grant_o[0], 2'b01);

    // Repeated ties: priority always m1, round-robin alternates from m0.
    do_reset();
    m0_in.arvalid = 1'b1; m0_in.rready = 1'b1;
    m1_in.arvalid = 1'b1; m1_in.rready = 1'b1;
    s_in.arready = 1'b1; s_in.rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_rr_%0d", i), grant_o[1], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t4_prio_%0d", i), grant_o[0], 2'b10);
      tick();
    end

    // Watchdog: slave withholds R for 8 granted cycles.
    do_reset();
    m0_in.arvalid = 1'b1; m0_in.rready = 1'b1; s_in.arready = 1'b1;
    tick();
    m0_in.arvalid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_not_yet", tout[0], 1'b0);
    tick();
    chk("t5_expired", tout[0], 1'b1);
    s_in.rvalid = 1'b1; #1;
    chk("t5_late_r", m0_out[0].rvalid, 1'b1);
    tick();
    s_in.rvalid = 1'b0; #1;
    chk("t5_done", {grant_o[0], tout[0], tout[1]}, {2'b00, 1'b1, 1'b0});

    // Reset in the middle of a write after AW completed; stray B afterwards.
    do_reset();
    m1_in.awvalid = 1'b1; m1_in.wvalid = 1'b1; m1_in.bready = 1'b1; s_in.awready = 1'b1;
    tick();
    tick();
    m1_in.awvalid = 1'b0; s_in.awready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_idle", {grant_o[0], s_out[0].awvalid, s_out[0].wvalid, s_out[0].bready},
        {2'b00, 3'b000});
    m1_in.wvalid = 1'b0; s_in.bvalid = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk("t6_stray_b", {s_out[0].bready, m1_out[0].bvalid, grant_o[0]}, 4'b0000);

    // Random traffic against the reference model on both instances.
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      tick();
      m0_in = {$urandom, $urandom, $urandom, $urandom};
      m1_in = {$urandom, $urandom, $urandom, $urandom};
      s_in  = {$urandom, $urandom};
      m0_in.arvalid = ($urandom_range(0, 2) == 0);
      m1_in.arvalid = ($urandom_range(0, 3) == 0);
      m1_in.awvalid = ($urandom_range(0, 5) == 0);
      m1_in.wvalid  = ($urandom_range(0, 5) == 0);
      s_in.rvalid   = ($urandom_range(0, 3) == 0);
      s_in.bvalid   = ($urandom_range(0, 3) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        model_out(k, e0, e1, es, eg);
        chk($sformatf("rnd%0d_m0_c%0d", k, i), m0_out[k], e0);
        chk($sformatf("rnd%0d_m1_c%0d", k, i), m1_out[k], e1);
        chk($sformatf("rnd%0d_s_c%0d", k, i), s_out[k], es);
        chk($sformatf("rnd%0d_grant_c%0d", k, i), grant_o[k], eg);
        chk($sformatf("rnd%0d_tmo_c%0d", k, i), tout[k], stky[k]);
        model_step(k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
